// File: rtl/phy_rx_lanes.sv
// -----------------------------------------------------------------------------
// phy_rx_lanes
//
// Multi-lane serial PHY receiver. Each lane shifts in one bit per clock,
// acquires byte alignment on the COMMA character (SYNC_COUNT consecutive
// aligned commas), then packs non-comma bytes into WORD_BYTES-wide words
// and queues them in a small per-lane FIFO. A strict round-robin unstriper
// drains the lane FIFOs in lane order into a single word stream.
//
// Parameters:
//   LANES       number of serial lanes (>=1)
//   WORD_BYTES  bytes per output word
//   SYNC_COUNT  consecutive aligned commas required for lock (>=1)
//   FIFO_DEPTH  words buffered per lane (>=1)
//   COMMA       idle / alignment character
//
// Ports:
//   clk          bit-rate clock, all logic on rising edge
//   reset        synchronous, active-high
//   data_in      one serial bit per lane, MSB of each byte first
//   valid_out    one-cycle pulse, data_out holds a new word
//   data_out     merged word, first received byte in the MSBs
//   overflow     sticky, a word was dropped on a full lane FIFO
//   lane_locked  per-lane lock status (only when PHY_RX_LOCK_STATUS_EN
//                is defined)
//
// Optional feature macro: PHY_RX_LOCK_STATUS_EN adds the lane_locked port.
// -----------------------------------------------------------------------------
module phy_rx_lanes #(
  parameter int          LANES      = 2,
  parameter int          WORD_BYTES = 4,
  parameter int          SYNC_COUNT = 4,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [7:0]  COMMA      = 8'hBC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        data_in,
  output logic                    valid_out,
  output logic [8*WORD_BYTES-1:0] data_out,
  output logic                    overflow
`ifdef PHY_RX_LOCK_STATUS_EN
  ,
  output logic [LANES-1:0]        lane_locked
`endif
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CNT_W = $clog2(SYNC_COUNT + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = (LANES > 1) ? $clog2(LANES) : 1;

  // LOCKED owns its own state bit so lock status is a plain register bit.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_ALIGN    = 2'b01,
    ST_LOCKED   = 2'b10
  } lane_state_t;

  logic [LANES-1:0][W-1:0] head;
  logic [LANES-1:0]        nonempty;
  logic [LANES-1:0]        pop;
  logic [LANES-1:0]        drop;
  logic [RR_W-1:0]         rr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = ptr + PTR_W'(1);
    end
  endfunction

  // Only the lane under the round-robin pointer may be popped.
  always_comb begin
    pop = '0;
    if (nonempty[rr]) begin
      pop[rr] = 1'b1;
    end else begin
      pop = '0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0]       win;
    lane_state_t      state;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] comma_cnt;
    logic [IDX_W-1:0] byte_idx;
    logic [W-1:0]     word;
    logic [W-1:0]     word_next;
    logic             boundary;
    logic             push;
    logic             full;
    logic             accept;
    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    // Byte boundary decode, slot insertion of the current byte, FIFO status.
    always_comb begin
      boundary  = (bit_cnt == 3'd7);
      word_next = word;
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (byte_idx == IDX_W'(b)) begin
          word_next[(WORD_BYTES-1-b)*8 +: 8] = win;
        end else begin
          word_next[(WORD_BYTES-1-b)*8 +: 8] = word[(WORD_BYTES-1-b)*8 +: 8];
        end
      end
      push   = (state == ST_LOCKED) && boundary && (win != COMMA) &&
               (byte_idx == IDX_W'(WORD_BYTES - 1));
      full   = (occ == OCC_W'(FIFO_DEPTH));
      // A simultaneous pop frees a slot, so a full FIFO can still take the word.
      accept = push && (!full || pop[i]);
    end

    assign drop[i]     = push && full && !pop[i];
    assign nonempty[i] = (occ != '0);
    assign head[i]     = mem[rd_ptr];

    // Shift window, alignment/lock FSM, word assembly and FIFO pointers.
    always_ff @(posedge clk) begin
      if (reset) begin
        win       <= 8'h00;
        state     <= ST_UNLOCKED;
        bit_cnt   <= 3'd0;
        comma_cnt <= '0;
        byte_idx  <= '0;
        word      <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        occ       <= '0;
      end else begin
        win     <= {win[6:0], data_in[i]};
        bit_cnt <= bit_cnt + 3'd1;
        case (state)
          ST_UNLOCKED: begin
            // Free-running search: the cycle of a match defines the byte grid.
            if (win == COMMA) begin
              bit_cnt  <= 3'd0;
              byte_idx <= '0;
              if (SYNC_COUNT == 1) begin
                state <= ST_LOCKED;
              end else begin
                comma_cnt <= CNT_W'(1);
                state     <= ST_ALIGN;
              end
            end
          end
          ST_ALIGN: begin
            if (boundary) begin
              if (win == COMMA) begin
                if (comma_cnt == CNT_W'(SYNC_COUNT - 1)) begin
                  state <= ST_LOCKED;
                end else begin
                  comma_cnt <= comma_cnt + CNT_W'(1);
                end
              end else begin
                state     <= ST_UNLOCKED;
                comma_cnt <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (boundary) begin
              if (win == COMMA) begin
                // Idle mid-word throws the partial word away.
                byte_idx <= '0;
              end else if (push) begin
                byte_idx <= '0;
              end else begin
                byte_idx <= byte_idx + IDX_W'(1);
                word     <= word_next;
              end
            end
          end
          default: begin
            state <= ST_UNLOCKED;
          end
        endcase

        if (accept) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop[i]) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        case ({accept, pop[i]})
          2'b10:   occ <= occ + OCC_W'(1);
          2'b01:   occ <= occ - OCC_W'(1);
          default: occ <= occ;
        endcase
      end
    end

    // FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
      if (accept) begin
        mem[wr_ptr] <= word_next;
      end
    end

`ifdef PHY_RX_LOCK_STATUS_EN
    assign lane_locked[i] = (state == ST_LOCKED);
`endif
  end

  // Round-robin unstriper with registered outputs and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr        <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= overflow | (|drop);
      if (nonempty[rr]) begin
        valid_out <= 1'b1;
        data_out  <= head[rr];
        if (rr == RR_W'(LANES - 1)) begin
          rr <= '0;
        end else begin
          rr <= rr + RR_W'(1);
        end
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phy_rx_lanes.sv
// -----------------------------------------------------------------------------
// tb_phy_rx_lanes
//
// Directed bench for phy_rx_lanes (LANES=2, WORD_BYTES=4, SYNC_COUNT=4,
// FIFO_DEPTH=2, COMMA=8'hBC). Stimulus is queued as per-lane bit streams;
// a driver shifts them out one bit per clock and pads with a per-lane filler
// byte so every lane keeps its own byte grid. Expected words go into a
// scoreboard queue; a monitor pops and compares on every valid_out pulse.
// -----------------------------------------------------------------------------
module tb_phy_rx_lanes;

  localparam logic [7:0] K = 8'hBC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  data_in = 2'b00;
  logic        valid_out;
  logic [31:0] data_out;
  logic        overflow;
`ifdef PHY_RX_LOCK_STATUS_EN
  logic [1:0]  lane_locked;
`endif

  phy_rx_lanes dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .overflow    (overflow)
`ifdef PHY_RX_LOCK_STATUS_EN
    ,
    .lane_locked (lane_locked)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  bit          q0[$];
  bit          q1[$];
  logic [7:0]  fill0 = 8'h00;
  logic [7:0]  fill1 = 8'h00;
  logic [7:0]  cur0 = 8'h00;
  logic [7:0]  cur1 = 8'h00;
  int          fp0 = 0;
  int          fp1 = 0;
  bit          rand_mode = 1'b1;
  int          drain0 = 0;
  logic [31:0] exp_q[$];
  int          vcyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_bits(input int lane, input logic [7:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      if (lane == 0) q0.push_back(v[k]);
      else           q1.push_back(v[k]);
    end
  endtask

  task automatic push_commas(input int lane, input int n);
    for (int k = 0; k < n; k++) push_bits(lane, K, 8);
  endtask

  task automatic push_word(input int lane, input logic [31:0] w);
    for (int b = 3; b >= 0; b--) push_bits(lane, w[b*8 +: 8], 8);
  endtask

  // Driver: new bits appear 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        data_in = 2'($urandom);
        fp0 = 0;
        fp1 = 0;
      end else begin
        if (fp0 == 0 && q0.size() != 0) begin
          data_in[0] = q0.pop_front();
          if (q0.size() == 0) drain0 = cyc + 1;
        end else begin
          if (fp0 == 0) cur0 = fill0;
          data_in[0] = cur0[7 - fp0];
          fp0 = (fp0 + 1) % 8;
        end
        if (fp1 == 0 && q1.size() != 0) begin
          data_in[1] = q1.pop_front();
        end else begin
          if (fp1 == 0) cur1 = fill1;
          data_in[1] = cur1[7 - fp1];
          fp1 = (fp1 + 1) % 8;
        end
      end
    end
  end

  // Monitor: scoreboard comparison on every output pulse.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        vcyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_word", data_out, e);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rand_mode = 1'b1;
    q0.delete();
    q1.delete();
    exp_q.delete();
    vcyc.delete();
    fill0 = 8'h00;
    fill1 = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_data", data_out, 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
    end
    reset = 1'b0;
    rand_mode = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(valid_out), 32'd0);
    chk("post_rst_data", data_out, 32'd0);
    chk("post_rst_ovf", 32'(overflow), 32'd0);
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (16) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset behaviour with random serial input.
    do_reset();

    // Basic lock and merge, lanes aligned.
    push_commas(0, 4); push_word(0, 32'h11223344);
    push_commas(1, 4); push_word(1, 32'h55667788);
    fill0 = K; fill1 = K;
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'h55667788);
    settle(2000);
    chk("basic_count", 32'(vcyc.size()), 32'd2);
    if (vcyc.size() >= 2) begin
      chk("basic_lat_e2", 32'(vcyc[0]), 32'(drain0 + 2));
      chk("basic_lat_e3", 32'(vcyc[1]), 32'(drain0 + 3));
    end

    // Lock with a 3-bit offset on lane0.
    do_reset();
    push_bits(0, 8'b0000_0101, 3);
    push_commas(0, 4); push_word(0, 32'hA1B2C3D4);
    push_commas(1, 4); push_word(1, 32'h0F1E2D3C);
    fill0 = K; fill1 = K;
    exp_q.push_back(32'hA1B2C3D4);
    exp_q.push_back(32'h0F1E2D3C);
    settle(2000);
    chk("offset_count", 32'(vcyc.size()), 32'd2);

    // Only three commas on lane0: no lock, lane1's word stays blocked.
    do_reset();
    push_commas(0, 3); push_word(0, 32'h11223344);
    push_commas(1, 4); push_word(1, 32'h55667788);
    fill1 = K;
    settle(2000);
    repeat (100) @(negedge clk);
    chk("nolock_no_valid", 32'(vcyc.size()), 32'd0);
`ifdef PHY_RX_LOCK_STATUS_EN
    chk("nolock_lane_locked", 32'(lane_locked), 32'd2);
`endif

    // Idle comma in the middle of a word discards the partial word.
    do_reset();
    push_commas(0, 4); push_bits(0, 8'hAA, 8); push_bits(0, 8'hBB, 8);
    push_commas(0, 1); push_word(0, 32'h01020304);
    push_commas(1, 7); push_word(1, 32'h0A0B0C0D);
    fill0 = K; fill1 = K;
    exp_q.push_back(32'h01020304);
    exp_q.push_back(32'h0A0B0C0D);
    settle(2000);
    chk("idle_count", 32'(vcyc.size()), 32'd2);

    // Skew: lane1 completes 20 bit times before lane0.
    do_reset();
    push_bits(0, 8'h00, 4);
    push_commas(0, 6); push_word(0, 32'hCAFEF00D);
    push_commas(1, 4); push_word(1, 32'h12345678);
    fill0 = K; fill1 = K;
    exp_q.push_back(32'hCAFEF00D);
    exp_q.push_back(32'h12345678);
    settle(2000);
    chk("skew_count", 32'(vcyc.size()), 32'd2);
    if (vcyc.size() >= 2) begin
      chk("skew_lat_e2", 32'(vcyc[0]), 32'(drain0 + 2));
      chk("skew_lat_e3", 32'(vcyc[1]), 32'(drain0 + 3));
    end

    // Overflow: lane0 locked but silent, lane1 sends three words.
    do_reset();
    push_commas(0, 4);
    fill0 = K;
    push_commas(1, 4);
    push_word(1, 32'hD1D1D1D1); push_word(1, 32'hD2D2D2D2); push_word(1, 32'hD3D3D3D3);
    fill1 = K;
    settle(2000);
    repeat (20) @(negedge clk);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_stall", 32'(vcyc.size()), 32'd0);
    push_word(0, 32'hA0A0A0A0);
    exp_q.push_back(32'hA0A0A0A0);
    exp_q.push_back(32'hD1D1D1D1);
    settle(2000);
    chk("ovf_sticky1", 32'(overflow), 32'd1);
    push_word(0, 32'hA1A1A1A1);
    exp_q.push_back(32'hA1A1A1A1);
    exp_q.push_back(32'hD2D2D2D2);
    settle(2000);
    repeat (50) @(negedge clk);
    chk("ovf_count", 32'(vcyc.size()), 32'd4);
    chk("ovf_sticky2", 32'(overflow), 32'd1);

    // Reset clears the sticky overflow.
    do_reset();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_rx_lanes.md
# phy_rx_lanes

Parametrised single-clock multi-lane PHY receiver. It takes `LANES` serial bit streams and, per lane, acquires byte alignment on the comma character, then packs data bytes into words. A round-robin unstriper merges the per-lane words into one word stream in lane order. It is the next-generation receive path, generalised in lane count, word width, lock depth and buffering, and adds bit-offset alignment, lane-skew absorption and overflow detection.

## Interface
- `LANES`, 2, number of serial lanes (≥1)
- `WORD_BYTES`, 4, bytes per output word
- `SYNC_COUNT`, 4, consecutive aligned commas required for lock (≥1)
- `FIFO_DEPTH`, 2, words buffered per lane (≥1)
- `COMMA`, 8'hBC, idle/alignment character
- `clk`  in  1  bit-rate clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `data_in`  in  LANES  serial bit per lane, MSB of each byte first
- `valid_out`  out  1  one-cycle pulse: `data_out` holds a new word
- `data_out`  out  8*WORD_BYTES  merged word, first received byte in MSBs
- `overflow`  out  1  sticky: a word was dropped on a full lane FIFO
- `lane_locked`  out  LANES  per-lane lock status (only with `PHY_RX_LOCK_STATUS_EN`)

## Operation
- One clock, one synchronous active-high reset, as already decided.
- Per lane, an 8-bit shift window: each cycle `win <= {win[6:0], data_in[i]}`.
- Lane FSM:
  - UNLOCKED: compare `win` to `COMMA` every cycle. On a match, zero the bit counter, set the comma count to 1 and go to ALIGN.
  - ALIGN: act at each byte boundary (8 bits after the previous boundary). If the byte equals `COMMA`, increment the count; reaching `SYNC_COUNT` moves the lane to LOCKED. Any other byte returns the lane to UNLOCKED with count 0. With `SYNC_COUNT`=1 the first match locks directly.
  - LOCKED: at each byte boundary:
    - `COMMA` byte is idle. It discards any partial word and resets the byte index.
    - Any other byte is data. It goes into slot `byte_idx`, MSB-first. On the `WORD_BYTES`-th byte the full word is pushed to the lane FIFO and the index resets.
  - Lock is left only by `reset`.
- Lane FIFO: `FIFO_DEPTH` entries. A push when full drops the incoming word and sets `overflow`. Push and pop in the same cycle are both honoured.
- Unstriper:
  - Pointer `rr` starts at 0.
  - If FIFO[`rr`] is non-empty: pop it, register the word to `data_out`, pulse `valid_out` and advance `rr` modulo `LANES`.
  - Otherwise wait; other lanes are never skipped. A silent lane therefore stalls output by design, and the other lanes fill and then overflow.
- Reset values:
  - Outputs: `valid_out`=0, `data_out`=0, `overflow`=0, `lane_locked`=0.
  - Internal state: all FSMs UNLOCKED, FIFOs empty, `rr`=0, windows 0.

## Timing
- Edge E samples the last bit of a word's final byte. The word is in the FIFO after edge E+1.
- `valid_out` is high after edge E+2 if that lane is at `rr` and its FIFO was empty. It is held for exactly one cycle.
- Maximum output rate is one word per cycle. Back-to-back pulses occur when consecutive lanes hold words.
- `data_out` keeps its last value while `valid_out`=0.
- Reset asserted mid-word or mid-lock: at the next edge all state returns to reset values and partial words are lost. The first edge after reset deasserts samples a fresh bit.

## Configuration
- `PHY_RX_LOCK_STATUS_EN` defined: port `lane_locked[i]` is 1 exactly while lane i is in LOCKED, registered with the FSM state.
- Macro undefined: the port and its logic are absent. Datapath behaviour is identical.

## Test plan
- Reset: hold `reset` for 3 cycles with random `data_in` -> `valid_out`=0, `data_out`=0, `overflow`=0 throughout and one cycle after release.
- Basic lock and merge, defaults: both lanes send 4×BC, then lane0 sends 0x11223344 and lane1 sends 0x55667788 aligned -> `data_out`=0x11223344 then 0x55667788 on consecutive cycles, the first at E+2.
- Bit-offset alignment: lane0 sends 3 junk bits 101 then 4×BC, then data -> lock is achieved and words are correct. Sending only 3×BC then data -> no lock and `valid_out` never asserts.
- Mid-word idle: locked lane0 sends 0xAA, 0xBB, BC, then 0x01020304, lane1 sends 0x0A0B0C0D -> `data_out` is 0x01020304 then 0x0A0B0C0D. No word contains 0xAA.
- Skew: lane1's word completes 20 cycles before lane0's -> output is still lane0 word first, then lane1 word on the next cycle.
- Overflow: lane1 sends 3 words while lane0 stays idle (`FIFO_DEPTH`=2) -> `overflow`=1 and stays 1. After lane0 sends a word, the outputs are lane0 word, then lane1 word 1, then (after another lane0 word) lane1 word 2; word 3 is lost. Asserting `reset` clears `overflow`.
